// File: rtl/watch_mode_controller.sv
// ---------------------------------------------------------------------------
// watch_mode_controller
//
// Top-level mode sequencer for the digital watch. Debounces the mode and set
// buttons, classifies mode presses as short or long, and walks the watch
// through time display, hour set, minute set and stopwatch. Button activity
// becomes single-cycle strobes for the timekeeping datapath and stopwatch.
//
// Parameters
//   DEBOUNCE    consecutive differing samples before a debounced level flips
//   LONG_PRESS  edges of debounced mode hold that make a long press
//
// Ports
//   clk_i                system clock
//   rst_ni               asynchronous active-low reset
//   mode_btn_i           raw mode button (already synchronous to clk_i)
//   set_btn_i            raw set button (already synchronous to clk_i)
//   split_mode_i         stopwatch status, 1 while in split-time mode
//   stopwatch_mode_en_o  stopwatch enable
//   sw_mode_o            strobe: toggle stopwatch elapsed/split mode
//   sw_set_o             strobe: stopwatch start/stop/split/clear
//   hour_inc_o           strobe: increment hours
//   min_inc_o            strobe: increment minutes
//   alarm_on_o           alarm arm flag
//   watch_state_o        current FSM state encoding
//
// States
//   state      | meaning
//   -----------+-------------------------------------------------------
//   TIME (0)   | time display; set toggles the alarm
//   SET_HR (1) | hour set; set increments hours
//   SET_MIN (2)| minute set; set increments minutes
//   STOPWATCH  | stopwatch enabled; set drives start/stop/split/clear
//   (3)        |
//   SW_EXIT (4)| one-cycle exit, stopwatch still enabled so it can be
//              | forced back to elapsed mode; all events ignored
//   5..7       | illegal, recover to TIME
// ---------------------------------------------------------------------------
module watch_mode_controller #(
    parameter int DEBOUNCE   = 4,
    parameter int LONG_PRESS = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       mode_btn_i,
    input  logic       set_btn_i,
    input  logic       split_mode_i,
    output logic       stopwatch_mode_en_o,
    output logic       sw_mode_o,
    output logic       sw_set_o,
    output logic       hour_inc_o,
    output logic       min_inc_o,
    output logic       alarm_on_o,
    output logic [2:0] watch_state_o
);

    localparam int DB_W   = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;
    localparam int HOLD_W = $clog2(LONG_PRESS + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS - 1);

    localparam logic [2:0] ST_TIME      = 3'd0;
    localparam logic [2:0] ST_SET_HR    = 3'd1;
    localparam logic [2:0] ST_SET_MIN   = 3'd2;
    localparam logic [2:0] ST_STOPWATCH = 3'd3;
    localparam logic [2:0] ST_SW_EXIT   = 3'd4;

    // -----------------------------------------------------------------------
    // Set button debounce and rise strobe
    // -----------------------------------------------------------------------
    logic [DB_W-1:0] set_cnt_q, set_cnt_d;
    logic            set_deb_q, set_deb_d;
    logic            set_prev_q;
    logic            set_ev_q, set_ev_d;
    logic            set_diff, set_flip;

    always_comb begin
        set_diff  = set_btn_i ^ set_deb_q;
        set_flip  = set_diff && (set_cnt_q == DB_LAST);
        set_deb_d = set_flip ? set_btn_i : set_deb_q;
        if (!set_diff || set_flip) begin
            set_cnt_d = '0;
        end else begin
            set_cnt_d = set_cnt_q + DB_W'(1);
        end
        set_ev_d = set_deb_q && !set_prev_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            set_cnt_q  <= '0;
            set_deb_q  <= 1'b0;
            set_prev_q <= 1'b0;
            set_ev_q   <= 1'b0;
        end else begin
            set_cnt_q  <= set_cnt_d;
            set_deb_q  <= set_deb_d;
            set_prev_q <= set_deb_q;
            set_ev_q   <= set_ev_d;
        end
    end

    // -----------------------------------------------------------------------
    // Mode button debounce, hold counter and short/long classification
    // -----------------------------------------------------------------------
    logic [DB_W-1:0]   mode_cnt_q, mode_cnt_d;
    logic              mode_deb_q, mode_deb_d;
    logic              mode_prev_q;
    logic              mode_diff, mode_flip;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              short_ev_q, short_ev_d;
    logic              long_ev_q, long_ev_d;

    always_comb begin
        mode_diff  = mode_btn_i ^ mode_deb_q;
        mode_flip  = mode_diff && (mode_cnt_q == DB_LAST);
        mode_deb_d = mode_flip ? mode_btn_i : mode_deb_q;
        if (!mode_diff || mode_flip) begin
            mode_cnt_d = '0;
        end else begin
            mode_cnt_d = mode_cnt_q + DB_W'(1);
        end

        // The counter keeps counting on the edge the level falls, so a press
        // that reaches LONG_PRESS on that edge still reports long, not short.
        hold_d = hold_q;
        if (mode_flip && mode_btn_i) begin
            hold_d = '0;
        end else if (mode_deb_q && (hold_q != HOLD_MAX)) begin
            hold_d = hold_q + HOLD_W'(1);
        end

        // Saturation guarantees hold_q passes LONG_PRESS-1 once per press.
        long_ev_d  = mode_deb_q && (hold_q == HOLD_LAST);
        short_ev_d = !mode_deb_q && mode_prev_q && (hold_q < HOLD_MAX);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mode_cnt_q  <= '0;
            mode_deb_q  <= 1'b0;
            mode_prev_q <= 1'b0;
            hold_q      <= '0;
            short_ev_q  <= 1'b0;
            long_ev_q   <= 1'b0;
        end else begin
            mode_cnt_q  <= mode_cnt_d;
            mode_deb_q  <= mode_deb_d;
            mode_prev_q <= mode_deb_q;
            hold_q      <= hold_d;
            short_ev_q  <= short_ev_d;
            long_ev_q   <= long_ev_d;
        end
    end

    // -----------------------------------------------------------------------
    // Watch FSM
    // -----------------------------------------------------------------------
    logic [2:0] state_q, state_d;
    logic       alarm_q, alarm_d;
    logic       set_evt;
    logic       sw_en;
    logic       sw_mode_p;
    logic       sw_set_p;
    logic       hour_p;
    logic       min_p;

    // A mode event in the same cycle wins; the set event is dropped.
    assign set_evt = set_ev_q && !short_ev_q && !long_ev_q;

    always_comb begin
        state_d   = state_q;
        alarm_d   = alarm_q;
        sw_en     = 1'b0;
        sw_mode_p = 1'b0;
        sw_set_p  = 1'b0;
        hour_p    = 1'b0;
        min_p     = 1'b0;
        case (state_q)
            ST_TIME: begin
                if (short_ev_q) begin
                    state_d = ST_SET_HR;
                end else if (set_evt) begin
                    alarm_d = !alarm_q;
                end
            end
            ST_SET_HR: begin
                if (short_ev_q) begin
                    state_d = ST_SET_MIN;
                end else if (long_ev_q) begin
                    state_d = ST_TIME;
                end else if (set_evt) begin
                    hour_p = 1'b1;
                end
            end
            ST_SET_MIN: begin
                if (short_ev_q) begin
                    state_d = ST_STOPWATCH;
                end else if (long_ev_q) begin
                    state_d = ST_TIME;
                end else if (set_evt) begin
                    min_p = 1'b1;
                end
            end
            ST_STOPWATCH: begin
                sw_en = 1'b1;
                if (short_ev_q) begin
                    if (split_mode_i) begin
                        state_d = ST_SW_EXIT;
                    end else begin
                        sw_mode_p = 1'b1;
                    end
                end else if (long_ev_q) begin
                    state_d = ST_SW_EXIT;
                end else if (set_evt) begin
                    sw_set_p = 1'b1;
                end
            end
            ST_SW_EXIT: begin
                // Still enabled here so a split-mode stopwatch can be toggled
                // back to elapsed mode before it is switched off.
                sw_en     = 1'b1;
                sw_mode_p = split_mode_i;
                state_d   = ST_TIME;
            end
            default: begin
                state_d = ST_TIME;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_TIME;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            alarm_q <= alarm_d;
        end
    end

    assign stopwatch_mode_en_o = sw_en;
    assign sw_mode_o           = sw_mode_p;
    assign sw_set_o            = sw_set_p;
    assign hour_inc_o          = hour_p;
    assign min_inc_o           = min_p;
    assign alarm_on_o          = alarm_q;
    assign watch_state_o       = state_q;

endmodule
